booth_r4_ctrl: RTL and testbench

Sequencing controller for the radix-4 Booth multiplier datapath: accumulator A (9-bit), multiplier register Q with Q[-1], multiplicand register M, and the parallel adder. It accepts a start request, issues the one-cycle control strobes c0/c1/c2/c5/c6 in the correct order, and recodes the current Booth digit into adder operation selects. It counts the ITER add/shift iterations and signals completion with a one-cycle `done`.

---
 rtl/booth_r4_ctrl_if.sv | 27 ++
 rtl/booth_r4_ctrl.sv | 101 ++++++++++
 tb/tb_booth_r4_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/booth_r4_ctrl_if.sv
// Control bundle between the radix-4 Booth sequencer and its datapath.
// Master drives start/q_bits; slave (the sequencer) drives status and strobes.
interface booth_r4_ctrl_if;
  logic       start;
  logic [2:0] q_bits;
  logic       busy;
  logic       done;
  logic       c0;
  logic       c1;
  logic       c2;
  logic       c5;
  logic       c6;
  logic       sel_2m;
  logic       sub;

  modport master (
    output start, q_bits,
    input  busy, done, c0, c1, c2, c5, c6,
    input  sel_2m, sub
  );

  modport slave (
    input  start, q_bits,
    output busy, done, c0, c1, c2, c5, c6,
    output sel_2m, sub
  );
endinterface

// File: rtl/booth_r4_ctrl.sv
// Radix-4 Booth multiplier sequencer: strobes, digit recoding, iteration count.
// Define BOOTH_SKIP_ZERO_EN to skip the ADD cycle for zero digits (000/111).
module booth_r4_ctrl #(
  parameter int ITER  = 4,
  parameter int CNT_W = 2
) (
  input logic          clk,
  input logic          reset,
  booth_r4_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    SHIFT,
    OUT
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             skip;

  assign last = (cnt == CNT_W'(ITER - 1));

`ifdef BOOTH_SKIP_ZERO_EN
  assign skip = (bus.q_bits == 3'b000) ||
                (bus.q_bits == 3'b111);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE:    nxt = bus.start ? LOAD : IDLE;
      LOAD:    nxt = skip ? SHIFT : ADD;
      ADD:     nxt = SHIFT;
      SHIFT:   nxt = last ? OUT : (skip ? SHIFT : ADD);
      OUT:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Strobes are registered decodes of the next state, so each one is
  // high exactly while the state register holds the matching state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.c0   <= 1'b0;
      bus.c1   <= 1'b0;
      bus.c2   <= 1'b0;
      bus.c5   <= 1'b0;
      bus.c6   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == LOAD)
        cnt <= '0;
      else if (state == SHIFT)
        cnt <= cnt + CNT_W'(1);
      bus.busy <= (nxt != IDLE);
      bus.done <= (nxt == OUT);
      bus.c0   <= (nxt == LOAD);
      bus.c1   <= (nxt == LOAD);
      bus.c2   <= (nxt == ADD);
      bus.c5   <= (nxt == SHIFT);
      bus.c6   <= (nxt == OUT);
    end
  end

  // Operand selects follow the live digit, gated by the ADD strobe.
  always_comb begin
    bus.sel_2m = 1'b0;
    bus.sub    = 1'b0;
    if (bus.c2) begin
      unique case (1'b1)
        (bus.q_bits == 3'b011): begin
          bus.sel_2m = 1'b1;
        end
        (bus.q_bits == 3'b100): begin
          bus.sel_2m = 1'b1;
          bus.sub    = 1'b1;
        end
        (bus.q_bits == 3'b101),
        (bus.q_bits == 3'b110): begin
          bus.sub = 1'b1;
        end
        default: begin
          bus.sel_2m = 1'b0;
          bus.sub    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_ctrl.sv
// Bench for booth_r4_ctrl: directed sequences then random start/q_bits/reset,
// compared cycle by cycle against a schedule-based reference model.
module tb_booth_r4_ctrl;

  localparam int ITER = 4;
  localparam int OUTC = 2 * ITER + 2;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;
  int   cyc;

  booth_r4_ctrl_if bif ();

  booth_r4_ctrl #(
    .ITER  (ITER),
    .CNT_W (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: t = cycle index within an operation (0 = idle, 1 = load).
  int t;
  // Skip-zero model: phase 0 idle,1 load,2 add,3 shift,4 out; it = shifts done.
  int ph;
  int it;

  function automatic bit zero_digit(input logic [2:0] q);
    return (q == 3'b000) || (q == 3'b111);
  endfunction

  function automatic logic [8:0] expect_outs(input logic [2:0] q);
    int  d;
    bit  busy, load, add, shf, outp, s2m, sb;
`ifdef BOOTH_SKIP_ZERO_EN
    busy = (ph != 0);
    load = (ph == 1);
    add  = (ph == 2);
    shf  = (ph == 3);
    outp = (ph == 4);
`else
    busy = (t != 0);
    load = (t == 1);
    add  = (t >= 2) && (t <= OUTC - 1) && (t % 2 == 0);
    shf  = (t >= 2) && (t <= OUTC - 1) && (t % 2 == 1);
    outp = (t == OUTC);
`endif
    d   = -2 * int'(q[2]) + int'(q[1]) + int'(q[0]);
    s2m = add && (d == 2 || d == -2);
    sb  = add && (d < 0);
    return {busy, outp, load, load, add, shf, outp, s2m, sb};
  endfunction

  task automatic model_clock(input logic s, input logic [2:0] q);
`ifdef BOOTH_SKIP_ZERO_EN
    case (ph)
      0: ph = s ? 1 : 0;
      1: begin it = 0; ph = zero_digit(q) ? 3 : 2; end
      2: ph = 3;
      3: begin
        it = it + 1;
        if (it == ITER) ph = 4;
        else ph = zero_digit(q) ? 3 : 2;
      end
      default: ph = 0;
    endcase
`else
    if (t == 0) t = s ? 1 : 0;
    else if (t == OUTC) t = 0;
    else t = t + 1;
`endif
  endtask

  task automatic model_reset();
    t  = 0;
    ph = 0;
    it = 0;
  endtask

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%b exp=%b {busy,done,c0,c1,c2,c5,c6,sel_2m,sub}",
               tag, cyc, got, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bif.busy, bif.done, bif.c0, bif.c1, bif.c2,
            bif.c5, bif.c6, bif.sel_2m, bif.sub};
  endfunction

  task automatic step(input logic s, input logic [2:0] q, input logic r, input string tag);
    @(negedge clk);
    bif.start  = s;
    bif.q_bits = q;
    reset      = r;
    if (r) begin
      model_reset();
      #1;
      check("reset_imm", outs(), expect_outs(q));
    end
    @(posedge clk);
    cyc++;
    if (r) model_reset();
    else model_clock(s, q);
    #1;
    check(tag, outs(), expect_outs(q));
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    cyc  = 0;
    model_reset();
    bif.start  = 1'b0;
    bif.q_bits = 3'b000;
    reset      = 1'b1;
    #1;
    check("reset_state", outs(), 9'b0);
    step(1'b0, 3'b000, 1'b1, "reset_hold");

    // single start, q_bits constant 000
    step(1'b1, 3'b000, 1'b0, "pulse");
    for (int i = 0; i < 14; i++) step(1'b0, 3'b000, 1'b0, "pulse");

    // recoding patterns during ADD
    for (int i = 0; i < 16; i++) begin
      logic [2:0] pat [4];
      pat[0] = 3'b011; pat[1] = 3'b100; pat[2] = 3'b110; pat[3] = 3'b010;
      step(i == 0, pat[i % 4], 1'b0, "recode");
    end

    // start held high: back-to-back operations
    for (int i = 0; i < 36; i++) step(1'b1, 3'b111, 1'b0, "held");
    for (int i = 0; i < 12; i++) step(1'b0, 3'b001, 1'b0, "drain");

    // start pulses while busy are ignored
    for (int i = 0; i < 14; i++)
      step(i == 0 || i == 3 || i == 7, 3'b101, 1'b0, "ignore");

    // mid-operation reset, then restart
    for (int i = 0; i < 20; i++)
      step(i == 0 || i == 8, 3'(i), i == 5, "abort");

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 149) == 0, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
